// File: rtl/oet_sorter_if.sv
// Streaming handshake bundle for the oet_sorter frame sort stage.
// master drives words in and accepts sorted words; slave is the sorter.
interface oet_sorter_if #(
  parameter int DATAWIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] in_data;
  logic                 descend;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_data;
  logic                 out_last;

  modport master (
    output in_valid, in_data, descend, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, descend, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/oet_sorter.sv
// Odd-even transposition frame sorter: LOAD -> SORT -> UNLOAD.
// Define OET_EARLY_EXIT_EN to end SORT after two swap-free phases.
module oet_sorter #(
  parameter int DATAWIDTH = 8,
  parameter int SIZE      = 16,
  parameter int ADDRWIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  oet_sorter_if.slave      io,
  output logic             busy,
  output logic             done,
  output logic [ADDRWIDTH:0] phases
);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_SORT   = 2'd1;
  localparam logic [1:0] S_UNLOAD = 2'd2;

  localparam logic [ADDRWIDTH-1:0] PTR_LAST = ADDRWIDTH'(SIZE - 1);
  localparam logic [ADDRWIDTH:0]   PH_LAST  = (ADDRWIDTH + 1)'(SIZE - 1);

  logic [1:0]           state_q, state_d;
  logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                 ord_q, ord_d;
  logic [ADDRWIDTH:0]   phases_q, phases_d;
  logic                 done_q, done_d;
  logic [DATAWIDTH-1:0] mem_q [SIZE];
  logic [DATAWIDTH-1:0] mem_d [SIZE];
  logic                 sort_exit;
`ifdef OET_EARLY_EXIT_EN
  logic                 swap_any;
  logic                 swp_prev_q, swp_prev_d;
`endif

  logic st_load, st_sort, st_unload;

  assign st_load   = (state_q == S_LOAD);
  assign st_sort   = (state_q == S_SORT);
  assign st_unload = (state_q == S_UNLOAD);

  assign io.in_ready  = st_load;
  assign io.out_valid = st_unload;
  assign io.out_data  = st_unload ? mem_q[rd_ptr_q] : '0;
  assign io.out_last  = st_unload && (rd_ptr_q == PTR_LAST);
  assign busy         = st_sort;
  assign done         = done_q;
  assign phases       = phases_q;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ord_d     = ord_q;
    phases_d  = phases_q;
    done_d    = 1'b0;
    mem_d     = mem_q;
    sort_exit = 1'b0;
`ifdef OET_EARLY_EXIT_EN
    swap_any   = 1'b0;
    swp_prev_d = 1'b0;
`endif
    unique case (1'b1)
      st_load: begin
        if (io.in_valid) begin
          mem_d[wr_ptr_q] = io.in_data;
          wr_ptr_d        = wr_ptr_q + 1'b1;
          if (wr_ptr_q == '0) begin
            ord_d    = io.descend;
            phases_d = '0;
          end
          if (wr_ptr_q == PTR_LAST) begin
            wr_ptr_d = '0;
            state_d  = S_SORT;
          end
        end
      end
      st_sort: begin
        // pairs start at even i on even phases, odd i on odd phases
        for (int i = 0; i < SIZE - 1; i++) begin
          if ((i & 1) == int'(phases_q[0])) begin
            if (ord_q ? (mem_q[i] < mem_q[i+1])
                      : (mem_q[i] > mem_q[i+1])) begin
              mem_d[i]   = mem_q[i+1];
              mem_d[i+1] = mem_q[i];
`ifdef OET_EARLY_EXIT_EN
              swap_any   = 1'b1;
`endif
            end
          end
        end
`ifdef OET_EARLY_EXIT_EN
        swp_prev_d = swap_any;
        sort_exit  = (phases_q == PH_LAST) ||
                     ((phases_q != '0) && !swap_any && !swp_prev_q);
`else
        sort_exit  = (phases_q == PH_LAST);
`endif
        phases_d = phases_q + 1'b1;
        if (sort_exit) begin
          state_d = S_UNLOAD;
          done_d  = 1'b1;
        end
      end
      st_unload: begin
        if (io.out_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == PTR_LAST) begin
            rd_ptr_d = '0;
            state_d  = S_LOAD;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_LOAD;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ord_q    <= 1'b0;
      phases_q <= '0;
      done_q   <= 1'b0;
`ifdef OET_EARLY_EXIT_EN
      swp_prev_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ord_q    <= ord_d;
      phases_q <= phases_d;
      done_q   <= done_d;
`ifdef OET_EARLY_EXIT_EN
      swp_prev_q <= swp_prev_d;
`endif
    end
  end

  // frame storage is intentionally not reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_oet_sorter.sv
// Scoreboard bench for oet_sorter: directed frames in, monitor checks out.
module tb_oet_sorter;

  typedef logic [7:0] frame_t [16];

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic       done;
  logic [4:0] phases;

  oet_sorter_if #(.DATAWIDTH(8)) io ();

  oet_sorter #(
    .DATAWIDTH(8),
    .SIZE(16),
    .ADDRWIDTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(io),
    .busy(busy),
    .done(done),
    .phases(phases)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb [$];
  int ph_q [$];
  int done_cnt = 0;
  bit mon_en = 1'b0;
  bit bp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // out_ready driver: 1,0,0,1 pattern under backpressure
  initial begin
    bit [3:0] pat;
    int cyc;
    pat = 4'b1001;
    cyc = 0;
    io.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      io.out_ready = bp_en ? pat[cyc%4] : 1'b1;
      cyc++;
    end
  end

  // monitor
  bit         stall_pend = 1'b0;
  bit         last_hs = 1'b0;
  logic [7:0] held_data;
  logic       held_last;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (last_hs) begin
        chk("ready_after_last", int'(io.in_ready), 1);
        chk("valid_after_last", int'(io.out_valid), 0);
      end
      if (stall_pend) begin
        chk("bp_valid", int'(io.out_valid), 1);
        chk("bp_data", int'(io.out_data), int'(held_data));
        chk("bp_last", int'(io.out_last), int'(held_last));
      end
      if (busy || io.out_valid)
        chk("in_blocked", int'(io.in_ready), 0);
      if (done) begin
        int ep;
        done_cnt++;
        chk("done_valid", int'(io.out_valid), 1);
        if (ph_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_extra: got done, expected none");
        end else begin
          ep = ph_q.pop_front();
          if (ep >= 0) chk("phases", int'(phases), ep);
        end
      end
      if (io.out_valid && io.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0d, expected none",
                   io.out_data);
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          chk("out_data", int'(io.out_data), int'(e[7:0]));
          chk("out_last", int'(io.out_last), int'(e[8]));
        end
      end
      stall_pend = io.out_valid && !io.out_ready;
      held_data  = io.out_data;
      held_last  = io.out_last;
      last_hs    = io.out_valid && io.out_ready && io.out_last;
    end else begin
      stall_pend = 1'b0;
      last_hs    = 1'b0;
    end
  end

  task automatic send_frame(input frame_t w, input frame_t e,
                            input bit desc, input int ph,
                            input bit push, input bit hold);
    if (push) begin
      for (int k = 0; k < 16; k++)
        sb.push_back({(k == 15), e[k]});
      ph_q.push_back(ph);
    end
    for (int k = 0; k < 16; k++) begin
      int n;
      io.in_valid = 1'b1;
      io.in_data  = w[k];
      io.descend  = (k == 0) ? desc : ~desc;
      n = 0;
      while (!io.in_ready && n < 500) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (!io.in_ready) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    io.in_data  = 8'hAA;
    io.in_valid = hold;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d words left, expected 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  frame_t rev, asc, desc_all, dup_in, dup_ex, mix_in, mix_ex;
  int ph_sorted, ph_var;

  initial begin
    for (int k = 0; k < 16; k++) begin
      rev[k]      = 8'(15 - k);
      asc[k]      = 8'(k);
      desc_all[k] = 8'(15 - k);
    end
    dup_in = '{3, 7, 3, 0, 255, 7, 1, 1, 9, 0, 3, 2, 8, 8, 4, 6};
    dup_ex = '{255, 9, 8, 8, 7, 7, 6, 4, 3, 3, 3, 2, 1, 1, 0, 0};
    mix_in = '{5, 4, 3, 2, 1, 0, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
    mix_ex = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 7, 8, 9, 10};
`ifdef OET_EARLY_EXIT_EN
    ph_sorted = 2;
    ph_var    = -1;
`else
    ph_sorted = 16;
    ph_var    = 16;
`endif

    rst_n       = 1'b0;
    io.in_valid = 1'b0;
    io.in_data  = '0;
    io.descend  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_in_ready", int'(io.in_ready), 1);
    chk("rst_out_valid", int'(io.out_valid), 0);
    chk("rst_out_last", int'(io.out_last), 0);
    chk("rst_out_data", int'(io.out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_phases", int'(phases), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // reversed ascending
    send_frame(rev, asc, 1'b0, 16, 1'b1, 1'b0);
    wait_idle();
    chk("done_cnt_1", done_cnt, 1);

    // descending duplicates, backpressure, in_valid held high
    bp_en = 1'b1;
    send_frame(dup_in, dup_ex, 1'b1, ph_var, 1'b1, 1'b1);
    wait_idle();
    io.in_valid = 1'b0;
    bp_en = 1'b0;
    chk("done_cnt_2", done_cnt, 2);

    // already sorted
    send_frame(asc, asc, 1'b0, ph_sorted, 1'b1, 1'b0);
    wait_idle();
    chk("done_cnt_3", done_cnt, 3);

    // reset on the third SORT cycle
    send_frame(asc, asc, 1'b1, 0, 1'b0, 1'b0);
    begin
      int n;
      n = 0;
      while (!busy && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("abort_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_in_ready", int'(io.in_ready), 1);
    chk("abort_busy_lo", int'(busy), 0);
    chk("abort_phases", int'(phases), 0);
    chk("abort_out_valid", int'(io.out_valid), 0);
    rst_n = 1'b1;
    send_frame(mix_in, mix_ex, 1'b0, ph_var, 1'b1, 1'b0);
    wait_idle();
    chk("done_cnt_4", done_cnt, 4);

    // back-to-back, second frame descending
    send_frame(rev, asc, 1'b0, 16, 1'b1, 1'b1);
    send_frame(asc, desc_all, 1'b1, ph_var, 1'b1, 1'b0);
    wait_idle();
    chk("done_cnt_6", done_cnt, 6);
    chk("ph_q_empty", ph_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/oet_sorter.md
# oet_sorter

Parametrised odd-even transposition sorter with valid/ready streaming on both sides. It accepts a frame of SIZE words, sorts it in place in a register array at one compare-exchange phase per cycle, ascending or descending, then streams the sorted frame out. It is the frame-level sort stage between the input buffer and the downstream consumer.

## Interface
- DATAWIDTH, 8: word width in bits, unsigned.
- SIZE, 16: words per frame; even, at least 4.
- ADDRWIDTH, 4: pointer width; must equal clog2(SIZE).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  sorter accepts a word this cycle.
- in_data  input  DATAWIDTH  input word.
- descend  input  1  sort order: 0 = ascending, 1 = descending; sampled with the first word of a frame.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  DATAWIDTH  sorted word.
- out_last  output  1  marks the final word of a frame.
- busy  output  1  asserted in SORT.
- done  output  1  one-cycle pulse on the first UNLOAD cycle.
- phases  output  ADDRWIDTH+1  number of phases executed for the current or last frame.

## Operation
- States are LOAD, SORT and UNLOAD. Outputs decode from registered state.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready cycle writes mem[wr_ptr] and increments wr_ptr.
  - On the first accepted word, descend is latched into ord and phases clears to 0.
  - On the SIZE-th accept: wr_ptr returns to 0, state moves to SORT.
- SORT, one phase per cycle:
  - Even phase (phase counter bit0=0) compares pairs (0,1),(2,3)…(SIZE-2,SIZE-1).
  - Odd phase compares pairs (1,2)…(SIZE-3,SIZE-2).
  - The first phase is even.
  - Swap rule for pair (i,i+1): if ord=0, swap when mem[i] > mem[i+1]; if ord=1, swap when mem[i] < mem[i+1].
  - Equal words never swap.
  - phases increments every SORT cycle.
  - The exit condition is set by the Configuration section. On exit, state moves to UNLOAD.
- UNLOAD:
  - out_valid=1 and out_data=mem[rd_ptr].
  - out_last=1 when rd_ptr==SIZE-1.
  - Each out_valid&&out_ready cycle increments rd_ptr.
  - After the handshake with out_last=1, rd_ptr returns to 0 and state moves to LOAD.
- Outside UNLOAD: out_valid=0, out_last=0, out_data=0.
- in_ready=0 in SORT and UNLOAD. in_valid is ignored there and no word is consumed.
- descend is only sampled on the first accepted word of a frame. Changes mid-frame have no effect.

## Timing
- Reset: the first clk edge with rst_n=0 forces the following, and holds them while rst_n stays 0:
  - state=LOAD, wr_ptr=0, rd_ptr=0, ord=0, phases=0.
  - in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0, done=0.
  - mem is not cleared.
- Reset asserted in any state, including mid-SORT or mid-UNLOAD, discards the frame. The next frame starts from word 0.
- Load latency: SIZE accept cycles, zero bubbles with in_valid held high.
- Sort latency: exactly `phases` cycles, with busy=1 throughout.
- Unload: the first word is valid in the cycle after the last SORT cycle, and done=1 in that cycle only. With out_ready held high, SIZE cycles.
- Back-to-back: in_ready rises in the cycle after the out_last handshake.
- Backpressure: out_ready=0 holds out_data, out_last and rd_ptr stable.

## Configuration
- OET_EARLY_EXIT_EN defined:
  - SORT tracks a per-phase "any swap" flag and the previous phase's flag.
  - SORT exits after the first phase where the current and previous phases both swapped nothing, minimum 2 phases.
  - SORT also exits after SIZE phases if that comes first.
- Undefined: SORT always runs exactly SIZE phases; phases=SIZE for every frame. The swap-tracking logic is not built.

## Test plan
- Ascending reversed frame: load 15,14,…,0 with descend=0 -> out 0,1,…,15; out_last only on 15; done pulses once; phases=16 in both configurations.
- Descending with duplicates: load 3,7,3,0,255,7,1,1,9,0,3,2,8,8,4,6 with descend=1 -> out 255,9,8,8,7,7,6,4,3,3,3,2,1,1,0,0.
- Early exit: load 0..15 ascending with descend=0 -> phases=2 with OET_EARLY_EXIT_EN, phases=16 without; output 0..15 in both.
- Backpressure: during UNLOAD toggle out_ready 1,0,0,1,… -> no word duplicated or dropped, out_data stable while out_ready=0; in_valid held high through SORT/UNLOAD consumes nothing.
- Reset mid-sort: assert rst_n=0 for one edge on the third SORT cycle -> next cycle in_ready=1, busy=0, phases=0; a new frame 5,4,…,0,10,…,1 (16 words) sorts correctly with no residue from the aborted frame.
- Back-to-back frames: two frames streamed with in_valid and out_ready held high -> in_ready rises the cycle after the first out_last; the second frame's descend value is honoured.
